// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the TX engine and its baud generator.
// Parity support is selected in the TX engine with the UART_TX_PARITY_EN macro.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    function automatic int unsigned clks_per_bit(int unsigned clk_freq, int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Request/serial-line bundle between the button debouncer, the TX engine and the TX pin.
interface uart_tx_engine_if;
    import uart_pkg::*;

    logic                   transmit;
    logic [UART_DATA_W-1:0] data;
    logic                   txd;
    logic                   busy;
    logic                   done;

    modport master (output transmit, output data, input txd, input busy, input done);
    modport slave  (input transmit, input data, output txd, output busy, output done);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs while enabled, cleared while disabled, strobes the last
// cycle of each bit (bit_end) and the cycle before it (pre_end).
module uart_baud_gen #(
    parameter int unsigned ClksPerBit = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_end,
    output logic pre_end
);

    localparam int unsigned CntW = $clog2(ClksPerBit);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_end = en && (cnt_q == CntW'(ClksPerBit - 1));
    assign pre_end = en && (cnt_q == CntW'(ClksPerBit - 2));

    always_comb begin
        cnt_d = cnt_q;
        if (!en || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: one 8N1 frame, LSB first, per rising edge of 'transmit'.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_engine_if.slave   bus
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD);

    uart_state_e            state_q, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             idx_q, idx_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   transmit_q;
    logic                   accept;
    logic                   bit_end;
    logic                   pre_end;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_baud_gen #(
        .ClksPerBit (ClksPerBit)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_q != StIdle),
        .bit_end (bit_end),
        .pre_end (pre_end)
    );

    assign accept = bus.transmit && !transmit_q && (state_q == StIdle);

    // Outputs are registered, so each is computed from the state being entered.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StStart;
                    shift_d = bus.data;
                    idx_d   = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.data;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    txd_d   = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        txd_d   = parity_q;
`else
                        state_d = StStop;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end
`endif
            StStop: begin
                // busy/done lead by one cycle so they land on the stop bit's final cycle.
                if (pre_end) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            idx_q      <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            transmit_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            transmit_q <= bus.transmit;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: frame-level reference model plus directed
// and randomized stimulus. Honours UART_TX_PARITY_EN when it is defined.
module tb_uart_tx_engine;

    localparam int unsigned Cpb = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBits = 11;
`else
    localparam int unsigned NBits = 10;
`endif
    localparam int unsigned FLen = NBits * Cpb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    // Reference model state.
    bit         m_active = 1'b0;
    int         m_start = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_prev = 1'b1;

    uart_tx_engine_if bus ();

    uart_tx_engine #(
        .CLK_FREQ (1000),
        .BAUD     (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: line level, busy and done at cycle c for a frame accepted at cycle s.
    always @(negedge clk) begin
        logic e_txd, e_busy, e_done;
        int k, b;
        e_txd  = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_prev   = 1'b1;
        end else begin
            if (m_active) begin
                k = cyc - m_start - 1;
                if (k >= FLen) begin
                    m_active = 1'b0;
                end else begin
                    b = k / Cpb;
                    if (b == 0) e_txd = 1'b0;
                    else if (b <= 8) e_txd = m_byte[b-1];
                    else if (NBits == 11 && b == 9) e_txd = ^m_byte;
                    else e_txd = 1'b1;
                    e_busy = (k < FLen - 1);
                    e_done = (k == FLen - 1);
                end
            end
        end
        chk("txd", bus.txd, e_txd);
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        if (bus.done === 1'b1) done_cnt++;
        if (rst_n) begin
            if (bus.transmit && !m_prev && !m_active) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_byte   = bus.data;
            end
            m_prev = bus.transmit;
        end
    end

    initial begin
        int n, d0;
        bus.transmit = 1'b0;
        bus.data     = 8'h00;
        tick(3);
        chk("reset_txd", bus.txd, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        rst_n = 1'b1;
        tick(3);

        // 1: A5 frame with literal timing points.
        bus.data = 8'hA5;
        bus.transmit = 1'b1;
        n = cyc;
        tick();
        bus.transmit = 1'b0;
        bus.data = 8'h3C;
        while (cyc < n + 102) begin
            case (cyc - n)
                1:   begin chk("t1_start", bus.txd, 0); chk("t1_busy_first", bus.busy, 1); end
                10:  chk("t1_start_end", bus.txd, 0);
                15:  chk("t1_bit0", bus.txd, 1);
                25:  chk("t1_bit1", bus.txd, 0);
                35:  chk("t1_bit2", bus.txd, 1);
                85:  chk("t1_bit7", bus.txd, 1);
                95:  chk("t1_stop", bus.txd, 1);
                99:  begin chk("t1_busy_last", bus.busy, 1); chk("t1_done_early", bus.done, 0); end
                100: begin chk("t1_done", bus.done, 1); chk("t1_busy_drop", bus.busy, 0); end
                101: chk("t1_done_once", bus.done, 0);
                default: ;
            endcase
            tick();
        end

        // 2: level held high for 500 cycles sends exactly one frame.
        d0 = done_cnt;
        bus.data = 8'h5A;
        bus.transmit = 1'b1;
        tick(500);
        bus.transmit = 1'b0;
        tick(5);
        chk("t2_one_frame", done_cnt - d0, 1);
        chk("t2_idle_txd", bus.txd, 1);

        // 3: second edge mid-frame with different data is ignored.
        d0 = done_cnt;
        bus.data = 8'hA5;
        bus.transmit = 1'b1;
        n = cyc;
        tick();
        bus.transmit = 1'b0;
        tick(n + 40 - cyc);
        bus.data = 8'hFF;
        bus.transmit = 1'b1;
        tick();
        bus.transmit = 1'b0;
        tick(200);
        chk("t3_one_frame", done_cnt - d0, 1);

        // 4: reset mid-frame abandons it, then a clean frame follows.
        d0 = done_cnt;
        bus.data = 8'hC3;
        bus.transmit = 1'b1;
        n = cyc;
        tick();
        bus.transmit = 1'b0;
        tick(n + 35 - cyc);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_txd", bus.txd, 1);
        chk("t4_rst_busy", bus.busy, 0);
        tick(3);
        rst_n = 1'b1;
        tick(150);
        chk("t4_no_done", done_cnt - d0, 0);
        bus.data = 8'h81;
        bus.transmit = 1'b1;
        tick();
        bus.transmit = 1'b0;
        tick(FLen + 5);
        chk("t4_clean_frame", done_cnt - d0, 1);

        // 5: level held through reset release sends nothing until low-then-high.
        d0 = done_cnt;
        rst_n = 1'b0;
        bus.transmit = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(150);
        chk("t5_no_frame", done_cnt - d0, 0);
        bus.transmit = 1'b0;
        tick();
        bus.transmit = 1'b1;
        tick();
        bus.transmit = 1'b0;
        tick(FLen + 5);
        chk("t5_after_toggle", done_cnt - d0, 1);

`ifdef UART_TX_PARITY_EN
        // 6: parity bit for 8'h07 and the longer frame.
        bus.data = 8'h07;
        bus.transmit = 1'b1;
        n = cyc;
        tick();
        bus.transmit = 1'b0;
        tick(n + 95 - cyc);
        chk("t6_parity", bus.txd, 1);
        tick(n + 110 - cyc);
        chk("t6_done", bus.done, 1);
        tick(5);
`endif

        // Randomized requests, mid-frame edges, data churn and occasional resets.
        for (int it = 0; it < 30; it++) begin
            int hi;
            tick($urandom_range(0, 20));
            hi = $urandom_range(1, 15);
            bus.transmit = 1'b1;
            for (int j = 0; j < hi; j++) begin
                bus.data = 8'($urandom);
                tick();
            end
            bus.transmit = 1'b0;
            for (int j = 0; j < 130; j++) begin
                bus.data = 8'($urandom);
                if ($urandom_range(0, 15) == 0) bus.transmit = ~bus.transmit;
                if ($urandom_range(0, 400) == 0) begin
                    rst_n = 1'b0;
                    tick(2);
                    rst_n = 1'b1;
                end
                tick();
            end
            bus.transmit = 1'b0;
        end
        tick(FLen + 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
